// File: rtl/read_channel_scheduler.sv
// Frame-boundary channel sequencer for the DDR read path. It merges key,
// auto-rotate and forced-skip requests into at most one valid-channel step per frame.
module read_channel_scheduler #(
  parameter int DWELL_FRAMES = 60,
  parameter int DW           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pulse,
  input  logic       auto_en,
  input  logic [3:0] ch_valid,
  input  logic       frame_done,
  output logic [1:0] read_channel,
  output logic       ch_switch,
  output logic       switch_pending,
  output logic       no_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    chan_q, chan_d;
  logic          sw_q, sw_d;
  logic          pend_q, pend_d;
  logic          nv_q, nv_d;
  logic [DW-1:0] cnt_q, cnt_d;

  logic       any_valid, cur_valid, forced, auto_due, found, do_switch;
  logic [1:0] next_ch, low_ch, cand;

  always_comb begin
    any_valid = |ch_valid;
    cur_valid = ch_valid[chan_q];
    forced    = !cur_valid && any_valid;
    auto_due  = auto_en && frame_done && (cnt_q == DW'(DWELL_FRAMES - 1));

    // Walk the offsets downward so the nearest valid successor is the one kept.
    found   = 1'b0;
    next_ch = chan_q;
    cand    = chan_q;
    for (int k = 3; k >= 1; k--) begin
      cand = chan_q + 2'(k);
      if (ch_valid[cand]) begin
        found   = 1'b1;
        next_ch = cand;
      end
    end

    low_ch = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (ch_valid[k]) low_ch = 2'(k);
    end

    do_switch = (state_q != S_IDLE) && frame_done && found &&
                (pend_q || key_pulse || auto_due || forced);

    state_d = state_q;
    chan_d  = chan_q;
    sw_d    = 1'b0;
    pend_d  = frame_done ? 1'b0 : (key_pulse ? 1'b1 : pend_q);
    nv_d    = !any_valid;

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d = S_SHOW;
          if (!cur_valid) begin
            chan_d = low_ch;
            sw_d   = 1'b1;
          end
        end
      end
      S_SHOW: if (key_pulse && !frame_done) state_d = S_WAIT;
      S_WAIT: if (frame_done) state_d = S_SHOW;
      default: state_d = S_IDLE;
    endcase

    if (do_switch) begin
      chan_d = next_ch;
      sw_d   = 1'b1;
    end
    if (!any_valid) state_d = S_IDLE;

    if (!auto_en || do_switch || auto_due) cnt_d = '0;
    else if (frame_done)                    cnt_d = cnt_q + DW'(1);
    else                                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      chan_q  <= 2'd0;
      sw_q    <= 1'b0;
      pend_q  <= 1'b0;
      nv_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      sw_q    <= sw_d;
      pend_q  <= pend_d;
      nv_q    <= nv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign read_channel   = chan_q;
  assign ch_switch      = sw_q;
  assign switch_pending = pend_q;
  assign no_valid       = nv_q;

endmodule

// File: tb/tb_read_channel_scheduler.sv
// Bench for read_channel_scheduler: per-cycle vectors with a queue of expected
// {read_channel, ch_switch, switch_pending, no_valid} values popped after each edge.
module tb_read_channel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_pulse, auto_en, frame_done;
  logic [3:0] ch_valid;
  logic [1:0] read_channel;
  logic       ch_switch, switch_pending, no_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       key;
    logic       au;
    logic [3:0] v;
    logic       fd;
    logic [4:0] e;   // {read_channel, ch_switch, switch_pending, no_valid}
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] sb[$];

  read_channel_scheduler #(.DWELL_FRAMES(3), .DW(16)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .auto_en(auto_en),
    .ch_valid(ch_valid), .frame_done(frame_done), .read_channel(read_channel),
    .ch_switch(ch_switch), .switch_pending(switch_pending), .no_valid(no_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(logic k, logic a, logic [3:0] v, logic f,
                               logic [1:0] rc, logic sw, logic p, logic nv);
    vec_t r;
    r.key = k; r.au = a; r.v = v; r.fd = f; r.e = {rc, sw, p, nv};
    return r;
  endfunction

  task automatic check(input logic [4:0] exp, input string nm);
    logic [4:0] act;
    act = {read_channel, ch_switch, switch_pending, no_valid};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rc=%0d sw=%b pend=%b nv=%b, expected rc=%0d sw=%b pend=%b nv=%b",
               nm, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic k, input logic a, input logic [3:0] v, input logic f,
                      input logic [4:0] e, input string nm);
    key_pulse = k; auto_en = a; ch_valid = v; frame_done = f;
    sb.push_back(e);
    @(posedge clk); #1;
    check(sb.pop_front(), nm);
  endtask

  initial begin
    // Key/skip/wrap, same-cycle key, forced move, no-valid, IDLE exit, dwell.
    tbl.push_back(row(1,0,4'b1011,0, 2'd1,0,1,0));
    tbl.push_back(row(1,0,4'b1011,0, 2'd1,0,1,0));
    tbl.push_back(row(1,0,4'b1011,0, 2'd1,0,1,0));
    tbl.push_back(row(0,0,4'b1011,1, 2'd3,1,0,0));  // skip ch2, single step
    tbl.push_back(row(0,0,4'b1011,0, 2'd3,0,0,0));
    tbl.push_back(row(1,0,4'b1011,0, 2'd3,0,1,0));
    tbl.push_back(row(0,0,4'b1011,1, 2'd0,1,0,0));  // wrap
    tbl.push_back(row(0,0,4'b1011,0, 2'd0,0,0,0));
    tbl.push_back(row(1,0,4'b1011,1, 2'd1,1,0,0));  // key+fd same cycle
    tbl.push_back(row(0,0,4'b1011,0, 2'd1,0,0,0));
    tbl.push_back(row(1,0,4'b1111,1, 2'd2,1,0,0));
    tbl.push_back(row(0,0,4'b0001,0, 2'd2,0,0,0));
    tbl.push_back(row(0,0,4'b0001,1, 2'd0,1,0,0));  // forced move
    tbl.push_back(row(1,0,4'b0011,1, 2'd1,1,0,0));
    tbl.push_back(row(0,0,4'b0000,0, 2'd1,0,0,1));
    tbl.push_back(row(1,0,4'b0000,1, 2'd1,0,0,1));  // no switch with nothing valid
    tbl.push_back(row(0,0,4'b0000,0, 2'd1,0,0,1));
    tbl.push_back(row(0,0,4'b0100,0, 2'd2,1,0,0));  // IDLE exit jumps to lowest valid
    tbl.push_back(row(0,0,4'b0100,0, 2'd2,0,0,0));
    tbl.push_back(row(1,0,4'b0100,0, 2'd2,0,1,0));
    tbl.push_back(row(0,0,4'b0100,1, 2'd2,0,0,0));  // only current valid: hold
    tbl.push_back(row(0,1,4'b1111,1, 2'd2,0,0,0));
    tbl.push_back(row(0,1,4'b1111,0, 2'd2,0,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd2,0,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd3,1,0,0));  // 3rd frame
    tbl.push_back(row(0,1,4'b1111,1, 2'd3,0,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd3,0,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd0,1,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd0,0,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd0,0,0,0));
    tbl.push_back(row(0,0,4'b1111,0, 2'd0,0,0,0));  // drop auto_en: count clears
    tbl.push_back(row(0,1,4'b1111,1, 2'd0,0,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd0,0,0,0));
    tbl.push_back(row(0,1,4'b1111,1, 2'd1,1,0,0));

    rst = 1'b1; key_pulse = 0; auto_en = 0; ch_valid = 4'h0; frame_done = 0;
    repeat (2) @(posedge clk);
    #1 check({2'd0,1'b0,1'b0,1'b1}, "reset_state");
    rst = 1'b0;

    // Key at cycle 10, frame_done at cycle 50.
    for (int i = 0; i < 10; i++) step(0,0,4'hF,0, {2'd0,3'b000}, "pre_key");
    step(1,0,4'hF,0, {2'd0,3'b010}, "key_latched");
    for (int i = 0; i < 39; i++) step(0,0,4'hF,0, {2'd0,3'b010}, "pending_hold");
    step(0,0,4'hF,1, {2'd1,3'b100}, "switch_0_to_1");
    step(0,0,4'hF,0, {2'd1,3'b000}, "switch_one_cycle");

    foreach (tbl[i]) step(tbl[i].key, tbl[i].au, tbl[i].v, tbl[i].fd, tbl[i].e,
                          $sformatf("vec%0d", i));

    // Async reset with pending set and dwell count nonzero.
    step(0,1,4'hF,1, {2'd1,3'b000}, "pre_rst_cnt1");
    step(0,1,4'hF,1, {2'd1,3'b000}, "pre_rst_cnt2");
    step(1,1,4'hF,0, {2'd1,3'b010}, "pre_rst_pend");
    rst = 1'b1;
    #2 check({2'd0,1'b0,1'b0,1'b1}, "async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    step(0,1,4'hF,0, {2'd0,3'b000}, "post_rst_no_pend");
    step(0,1,4'hF,1, {2'd0,3'b000}, "post_rst_fd1");
    step(0,1,4'hF,1, {2'd0,3'b000}, "post_rst_fd2");
    step(0,1,4'hF,1, {2'd1,3'b100}, "post_rst_fd3_auto");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_channel_scheduler.md
# read_channel_scheduler

Sequences which of the four camera frame-buffer channels the DDR read path displays. It collects operator advance requests (debounced key pulses) and optional automatic rotation, and commits a channel change only at a read-frame boundary so the output never tears mid-frame. Channels that hold no complete frame are skipped. The block sits between the key debounce logic and the DDR read-address generator, replacing a free-running key counter.

## Interface
Parameters:
- DWELL_FRAMES, 60: frames shown per channel in auto-rotate mode; legal range 1..65535.
- DW, 16: width of the dwell counter; must hold DWELL_FRAMES-1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- key_pulse  input  1  one-cycle advance request from debounce.
- auto_en  input  1  level; 1 = automatic rotation enabled.
- ch_valid  input  4  bit n = channel n has at least one complete frame in DDR.
- frame_done  input  1  one-cycle pulse when the reader finishes a frame; this is the only legal switch point.
- read_channel  output  2  channel currently selected for reading.
- ch_switch  output  1  one-cycle pulse, high in the first cycle a new read_channel value is driven.
- switch_pending  output  1  an advance request is latched and waiting for frame_done.
- no_valid  output  1  registered; high when ch_valid == 4'b0000.

## Operation
- Reset values: read_channel=0, ch_switch=0, switch_pending=0, no_valid=1, dwell counter=0.
- Pending latch: set by key_pulse. Cleared on every frame_done, whether or not a switch occurs. Multiple key pulses between two frame_done pulses collapse into a single advance.
- Auto dwell: counter increments on each frame_done while auto_en=1. auto_due = auto_en && frame_done && (count == DWELL_FRAMES-1). The counter clears on any switch, on auto_due, and whenever auto_en=0.
- Forced move: the current channel is invalid (ch_valid[read_channel]=0) and another channel is valid.
- Switch condition: frame_done && (switch_pending || key_pulse || auto_due || forced move).
- Next-channel search is circular from read_channel: try +1, then +2, then +3 (mod 4). The first one with ch_valid set wins.
  - If none of those is valid, no switch occurs and read_channel holds. If the current channel is also invalid, no_valid is asserted and read_channel still holds.
- Priority: all request sources merge into one advance of exactly one valid step per frame_done. There is never a double step.
- key_pulse and frame_done in the same cycle: the key is honored at that frame_done and pending does not remain set afterwards.
- State machine (2-bit): IDLE, SHOW, WAIT.
  - IDLE: entered while no_valid=1. Leaves to SHOW when any ch_valid bit sets. On that transition, read_channel jumps to the lowest valid channel if the current one is invalid, and ch_switch pulses.
  - SHOW → WAIT: on key_pulse without frame_done.
  - WAIT → SHOW: on frame_done.
  - Any state → IDLE: when ch_valid becomes 0.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- read_channel changes on the first clk edge after the cycle in which frame_done is sampled high with the switch condition true (1-cycle latency). ch_switch is high for exactly that one cycle.
- switch_pending rises the cycle after key_pulse and falls the cycle after frame_done.
- no_valid follows ch_valid with 1-cycle latency.
- ch_valid is a synchronous input in the clk domain; it is sampled in the same cycle as frame_done.
- Back-to-back frame_done pulses (every cycle) are legal; each can produce one switch.

## Test plan
- Reset, then ch_valid=4'hF, key_pulse at cycle 10, frame_done at cycle 50 → switch_pending=1 over cycles 11..50, read_channel 0→1 at cycle 51, one-cycle ch_switch.
- ch_valid=4'b1011, read_channel=1, three key pulses then one frame_done → read_channel=3 (channel 2 skipped, single step); next request plus frame_done → wraps to 0.
- auto_en=1, DWELL_FRAMES=3, ch_valid=4'hF → channel advances on every 3rd frame_done: 0,1,2,3,0. Dropping auto_en mid-dwell clears the count.
- key_pulse and frame_done in the same cycle → switch after 1 cycle, switch_pending never asserts.
- read_channel=2, ch_valid drops to 4'b0001, no key press → forced switch to 0 at the next frame_done. ch_valid=0 → no_valid=1, read_channel holds, and frame_done produces no switch.
- Assert rst while switch_pending=1 and the counter is nonzero → all outputs return to reset values immediately. With ch_valid=4'hF after release, no switch occurs without a new request.
